serial_paste_buffer: RTL and testbench
======================================

# serial_paste_buffer

- Sits between the external serial RX pin and the `rx` input of the machine's mc6850 ACIA.
- Receives host bytes at full line rate and stores them in a FIFO.
- Re-serialises them toward the ACIA with an enforced inter-character gap, and a longer gap after carriage return.
- Purpose: pasted program text into 4K BASIC must not overrun the single-byte ACIA receiver while the interpreter tokenises a line.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per serial bit, both sides (50 MHz / 115200). Minimum 4.
- `FIFO_AW`, default 6: FIFO address width; depth = 2^FIFO_AW = 64 bytes.
- `CHAR_GAP_CLKS`, default 50000: idle cycles inserted after every forwarded byte.
- `CR_GAP_CLKS`, default 5000000: idle cycles inserted after a forwarded 0x0D, replacing `CHAR_GAP_CLKS`.

Ports:
- `clk`  in  1  system clock, same clock as the CPU.
- `reset_n`  in  1  asynchronous, active-low reset.
- `host_rx`  in  1  serial 8N1 from host (asynchronous, idle high).
- `cpu_rx`  out  1  serial 8N1 to mc6850 `rx`; idle high.
- `fifo_count`  out  FIFO_AW+1  bytes currently stored, 0..2^FIFO_AW.
- `overrun`  out  1  sticky; set when a byte is dropped because the FIFO is full.
- `frame_err`  out  1  one-cycle pulse when a received stop bit samples 0.
- `busy`  out  1  high when the FIFO is non-empty or the TX FSM is not IDLE.

## Operation
- Reset is asynchronous. While `reset_n`=0, all outputs hold their reset values: `cpu_rx`=1, `fifo_count`=0, `overrun`=0, `frame_err`=0, `busy`=0.
  - Both FSMs go to IDLE; FIFO pointers go to 0.
  - FIFO storage is not cleared.
- Receiver:
  - `host_rx` passes through a 2-flop synchroniser.
  - RX FSM states: IDLE → START → DATA → STOP.
  - IDLE→START on a synchronised 1→0 transition.
  - START: wait CLKS_PER_BIT/2 (integer division), then sample. A 1 returns to IDLE (glitch rejected); a 0 goes to DATA.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. A 1 produces a byte-valid strobe; a 0 pulses `frame_err` and discards the byte. Both cases return to IDLE.
- FIFO:
  - Synchronous, single clock, 2^FIFO_AW entries.
  - Push on byte-valid strobe when not full. If full, the byte is dropped and `overrun` is set; it stays set until reset.
  - Full is evaluated before a same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle.
  - Simultaneous push and pop when not full: `fifo_count` is unchanged.
  - Pointers wrap modulo 2^FIFO_AW; full/empty are derived from `fifo_count`.
- Transmitter:
  - TX FSM states: IDLE → LOAD → START → DATA → STOP → GAP → IDLE.
  - IDLE with FIFO non-empty: pop and go to LOAD.
  - LOAD: registered FIFO read data is captured into the shift register.
  - START: `cpu_rx`=0 for CLKS_PER_BIT.
  - DATA: 8 bits LSB first, CLKS_PER_BIT each.
  - STOP: `cpu_rx`=1 for CLKS_PER_BIT.
  - GAP: `cpu_rx`=1 for CR_GAP_CLKS if the byte was 0x0D, otherwise CHAR_GAP_CLKS; then IDLE.
  - The gap counter must be at least 23 bits wide (holds CR_GAP_CLKS-1).
- Data is forwarded unmodified, subject to Configuration.

## Timing
- RX latency: `fifo_count` increments 1 cycle after the stop-bit sample clock.
- TX latency: falling edge of the `cpu_rx` start bit occurs 2 cycles after the IDLE pop (pop cycle, LOAD).
- Byte slot on `cpu_rx` = 10·CLKS_PER_BIT + gap + 2 cycles.
- `frame_err` is high for exactly one cycle, coincident with the STOP sample.
- `busy` is registered and follows FIFO/FSM state with 1 cycle of latency.
- Asynchronous reset mid-byte forces `cpu_rx`=1 immediately; no partial byte is resumed after release.

## Configuration
- `PASTE_LF_STRIP_EN` defined: received bytes equal to 0x0A are never pushed into the FIFO and do not affect `overrun` or `fifo_count`, so a host CR/LF becomes a bare CR.
- Not defined: 0x0A is stored and forwarded like any other byte.

## Test plan
- Send "10 PRINT 1\r" (11 bytes) back-to-back at CLKS_PER_BIT=16, CHAR_GAP_CLKS=40, CR_GAP_CLKS=400 -> `cpu_rx` reproduces the 11 bytes in order; each gap is 40 cycles, with 400 after 0x0D; `busy` falls afterwards; `overrun`=0.
- FIFO_AW=2: send 6 bytes while TX is held in a long gap -> 4 stored, `fifo_count`=4, remaining bytes dropped, `overrun`=1 and sticky until `reset_n` is pulsed.
- Send a byte with stop bit=0 -> `frame_err` pulses once; `fifo_count` stays 0; `cpu_rx` stays 1.
- Apply a 3-cycle low glitch on `host_rx` at CLKS_PER_BIT=16 -> no byte and no `frame_err`; RX returns to IDLE.
- Assert `reset_n`=0 during TX data bit 3 of 0x55 -> `cpu_rx`=1 in the same cycle; `fifo_count`=0; after release, no further output.
- With `PASTE_LF_STRIP_EN`: send 0x41 0x0D 0x0A -> output is 0x41 0x0D only; `fifo_count` peaks at 2. Without it: all 3 bytes are output.

Source files
------------

// File: rtl/serial_paste_buffer.sv
// Host-to-ACIA serial repeater: buffers line-rate host bytes in a FIFO and replays them with inter-character gaps.
// Optional build macro PASTE_LF_STRIP_EN drops received 0x0A bytes so CR/LF pastes arrive as bare CR.

module serial_paste_buffer #(
    parameter int CLKS_PER_BIT  = 434,
    parameter int FIFO_AW       = 6,
    parameter int CHAR_GAP_CLKS = 50000,
    parameter int CR_GAP_CLKS   = 5000000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               host_rx,
    output logic               cpu_rx,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overrun,
    output logic               frame_err,
    output logic               busy
);

    localparam int DEPTH   = 1 << FIFO_AW;
    localparam int CW      = FIFO_AW + 1;
    localparam int BIT_CW  = $clog2(CLKS_PER_BIT);
    localparam int GAP_MAX = (CR_GAP_CLKS > CHAR_GAP_CLKS) ? CR_GAP_CLKS : CHAR_GAP_CLKS;
    localparam int GAP_W   = ($clog2(GAP_MAX) > 23) ? $clog2(GAP_MAX) : 23;

    localparam logic [BIT_CW-1:0] BIT_LAST      = BIT_CW'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CW-1:0] HALF_LAST     = BIT_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [GAP_W-1:0]  CHAR_GAP_LAST = GAP_W'(CHAR_GAP_CLKS - 1);
    localparam logic [GAP_W-1:0]  CR_GAP_LAST   = GAP_W'(CR_GAP_CLKS - 1);
    localparam logic [CW-1:0]     FULL_COUNT    = CW'(DEPTH);

    if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
        $error("serial_paste_buffer: CLKS_PER_BIT must be at least 4");
    end

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_LOAD,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_GAP
    } tx_state_t;

    logic              rx_sync1_q, rx_sync1_d;
    logic              rx_sync2_q, rx_sync2_d;
    logic              rx_prev_q, rx_prev_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [BIT_CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]        rx_bit_q, rx_bit_d;
    logic [7:0]        rx_shift_q, rx_shift_d;
    logic              rx_valid;
    logic              rx_ferr;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [7:0]         rd_data_q, rd_data_d;
    logic               overrun_q, overrun_d;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;

    tx_state_t         tx_state_q, tx_state_d;
    logic [BIT_CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]        tx_bit_q, tx_bit_d;
    logic [7:0]        tx_shift_q, tx_shift_d;
    logic              tx_is_cr_q, tx_is_cr_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              cpu_rx_q, cpu_rx_d;
    logic              busy_q, busy_d;

    // Receiver: synchronise the pin, find the start edge, then sample mid-bit.
    always_comb begin
        rx_sync1_d = host_rx;
        rx_sync2_d = rx_sync1_q;
        rx_prev_d  = rx_sync2_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid   = 1'b0;
        rx_ferr    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync2_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_CW'(1);
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_CW'(1);
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                    if (rx_sync2_q) begin
                        rx_valid = 1'b1;
                    end else begin
                        rx_ferr = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + BIT_CW'(1);
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

`ifdef PASTE_LF_STRIP_EN
    assign push_req = rx_valid && (rx_shift_q != 8'h0A);
`else
    assign push_req = rx_valid;
`endif

    // Full is judged on the registered count, so a pop in the same cycle cannot rescue a push.
    always_comb begin
        fifo_full  = (count_q == FULL_COUNT);
        fifo_empty = (count_q == '0);
        push       = push_req && !fifo_full;
        overrun_d  = overrun_q || (push_req && fifo_full);
        wr_ptr_d   = push ? (wr_ptr_q + FIFO_AW'(1)) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + FIFO_AW'(1)) : rd_ptr_q;
        rd_data_d  = pop ? mem[rd_ptr_q] : rd_data_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        busy_d = (tx_state_q != TX_IDLE) || !fifo_empty;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_is_cr_d = tx_is_cr_q;
        gap_cnt_d  = gap_cnt_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                tx_shift_d = rd_data_q;
                tx_is_cr_d = (rd_data_q == 8'h0D);
                tx_cnt_d   = '0;
                tx_state_d = TX_START;
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_CW'(1);
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_shift_d = {1'b1, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_CW'(1);
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    gap_cnt_d  = '0;
                    tx_state_d = TX_GAP;
                end else begin
                    tx_cnt_d = tx_cnt_q + BIT_CW'(1);
                end
            end
            TX_GAP: begin
                if (gap_cnt_q == (tx_is_cr_q ? CR_GAP_LAST : CHAR_GAP_LAST)) begin
                    tx_state_d = TX_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level follows the next state so cpu_rx comes straight from a flop.
        case (tx_state_d)
            TX_START: cpu_rx_d = 1'b0;
            TX_DATA:  cpu_rx_d = tx_shift_d[0];
            default:  cpu_rx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync1_q <= 1'b1;
            rx_sync2_q <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            overrun_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_is_cr_q <= 1'b0;
            gap_cnt_q  <= '0;
            cpu_rx_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            rx_sync1_q <= rx_sync1_d;
            rx_sync2_q <= rx_sync2_d;
            rx_prev_q  <= rx_prev_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            overrun_q  <= overrun_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_is_cr_q <= tx_is_cr_d;
            gap_cnt_q  <= gap_cnt_d;
            cpu_rx_q   <= cpu_rx_d;
            busy_q     <= busy_d;
        end
    end

    // Storage keeps its contents across reset; only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign cpu_rx     = cpu_rx_q;
    assign fifo_count = count_q;
    assign overrun    = overrun_q;
    assign frame_err  = rx_ferr;
    assign busy       = busy_q;

endmodule

// File: tb/tb_serial_paste_buffer.sv
// Directed bench for serial_paste_buffer: a fast-gap instance for forwarding/timing and a tiny-FIFO instance for overrun.
// Honours PASTE_LF_STRIP_EN when deciding which bytes must appear on cpu_rx.

module tb_serial_paste_buffer;

    localparam int CPB = 16;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       host_rx_a = 1'b1;
    logic       host_rx_b = 1'b1;
    logic       cpu_rx_a, cpu_rx_b;
    logic [4:0] fifo_count_a;
    logic [2:0] fifo_count_b;
    logic       overrun_a, overrun_b;
    logic       frame_err_a, frame_err_b;
    logic       busy_a, busy_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] bytes_a [$];
    logic       stops_a [$];
    int         starts_a [$];
    int         ferr_count_a = 0;
    int         busy_fall_cyc = 0;
    logic       mon_prev = 1'b1;
    logic       busy_prev = 1'b0;

    vec_t vecs [11];

    serial_paste_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (4),
        .CHAR_GAP_CLKS(40),
        .CR_GAP_CLKS  (400)
    ) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .host_rx   (host_rx_a),
        .cpu_rx    (cpu_rx_a),
        .fifo_count(fifo_count_a),
        .overrun   (overrun_a),
        .frame_err (frame_err_a),
        .busy      (busy_a)
    );

    serial_paste_buffer #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (2),
        .CHAR_GAP_CLKS(4000),
        .CR_GAP_CLKS  (400)
    ) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .host_rx   (host_rx_b),
        .cpu_rx    (cpu_rx_b),
        .fifo_count(fifo_count_b),
        .overrun   (overrun_b),
        .frame_err (frame_err_b),
        .busy      (busy_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent 8N1 decoder on dut_a's output, sampling mid-bit from the start edge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_prev && !cpu_rx_a) begin
                starts_a.push_back(cyc);
                b = 8'h00;
                repeat (CPB + CPB / 2) @(negedge clk);
                b[0] = cpu_rx_a;
                for (int j = 1; j < 8; j++) begin
                    repeat (CPB) @(negedge clk);
                    b[j] = cpu_rx_a;
                end
                repeat (CPB) @(negedge clk);
                stops_a.push_back(cpu_rx_a);
                bytes_a.push_back(b);
            end
            mon_prev = cpu_rx_a;
        end
    end

    always @(negedge clk) begin
        if (frame_err_a) ferr_count_a = ferr_count_a + 1;
        if (busy_prev && !busy_a) busy_fall_cyc = cyc;
        busy_prev = busy_a;
    end

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic apply_stimulus(input int sel, input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (sel == 0) host_rx_a = frame[i];
            else          host_rx_b = frame[i];
            repeat (CPB - 1) @(negedge clk);
        end
    endtask

    initial begin
        int   ok;
        int   base;
        int   ferr_base;
        int   peak;
        int   s0;
        int   target;
        int   n_exp;
        logic [7:0] lf_exp [3];

        vecs[0]  = '{8'h31, 40};
        vecs[1]  = '{8'h30, 40};
        vecs[2]  = '{8'h20, 40};
        vecs[3]  = '{8'h50, 40};
        vecs[4]  = '{8'h52, 40};
        vecs[5]  = '{8'h49, 40};
        vecs[6]  = '{8'h4E, 40};
        vecs[7]  = '{8'h54, 40};
        vecs[8]  = '{8'h20, 40};
        vecs[9]  = '{8'h31, 40};
        vecs[10] = '{8'h0D, 400};
        lf_exp[0] = 8'h41;
        lf_exp[1] = 8'h0D;
        lf_exp[2] = 8'h0A;

        // Outputs while held in reset.
        repeat (4) @(negedge clk);
        check_output("rst_cpu_rx_a", int'(cpu_rx_a), 1);
        check_output("rst_count_a", int'(fifo_count_a), 0);
        check_output("rst_overrun_a", int'(overrun_a), 0);
        check_output("rst_frame_err_a", int'(frame_err_a), 0);
        check_output("rst_busy_a", int'(busy_a), 0);
        check_output("rst_cpu_rx_b", int'(cpu_rx_b), 1);
        check_output("rst_count_b", int'(fifo_count_b), 0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] forwarding \"10 PRINT 1\\r\"");
        base = bytes_a.size();
        for (int i = 0; i < 11; i++) apply_stimulus(0, vecs[i].data, 1'b1);
        ok = 0;
        for (int t = 0; t < 8000; t++) begin
            @(negedge clk);
            if (bytes_a.size() >= base + 11 && !busy_a && busy_fall_cyc > starts_a[base + 10]) begin
                ok = 1;
                break;
            end
        end
        check_output("t1_complete", ok, 1);
        if (ok == 1) begin
            for (int i = 0; i < 11; i++) begin
                check_output($sformatf("t1_byte%0d", i), int'(bytes_a[base + i]), int'(vecs[i].data));
                check_output($sformatf("t1_stop%0d", i), int'(stops_a[base + i]), 1);
                if (i < 10)
                    check_output($sformatf("t1_slot%0d", i),
                                 starts_a[base + i + 1] - starts_a[base + i], 10 * CPB + vecs[i].gap + 2);
                else
                    check_output("t1_cr_gap_busy_fall",
                                 busy_fall_cyc - starts_a[base + i], 10 * CPB + vecs[i].gap + 1);
            end
        end
        check_output("t1_overrun", int'(overrun_a), 0);
        check_output("t1_count_end", int'(fifo_count_a), 0);

        $display("[TB] framing error");
        ferr_base = ferr_count_a;
        s0 = starts_a.size();
        peak = 0;
        fork
            apply_stimulus(0, 8'h55, 1'b0);
            for (int t = 0; t < 200; t++) begin
                @(negedge clk);
                if (int'(fifo_count_a) > peak) peak = int'(fifo_count_a);
            end
        join
        host_rx_a = 1'b1;
        repeat (60) @(negedge clk);
        check_output("ferr_pulses", ferr_count_a - ferr_base, 1);
        check_output("ferr_count_peak", peak, 0);
        check_output("ferr_no_tx", starts_a.size() - s0, 0);
        check_output("ferr_cpu_rx", int'(cpu_rx_a), 1);

        $display("[TB] start-bit glitch");
        ferr_base = ferr_count_a;
        @(negedge clk);
        host_rx_a = 1'b0;
        repeat (3) @(negedge clk);
        host_rx_a = 1'b1;
        peak = 0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clk);
            if (int'(fifo_count_a) > peak) peak = int'(fifo_count_a);
        end
        check_output("glitch_no_ferr", ferr_count_a - ferr_base, 0);
        check_output("glitch_no_push", peak, 0);
        check_output("glitch_no_tx", starts_a.size() - s0, 0);
        base = bytes_a.size();
        apply_stimulus(0, 8'hA5, 1'b1);
        ok = 0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (bytes_a.size() > base) begin
                ok = 1;
                break;
            end
        end
        check_output("glitch_recover_seen", ok, 1);
        if (ok == 1) check_output("glitch_recover_byte", int'(bytes_a[base]), 8'hA5);
        repeat (300) @(negedge clk);

        $display("[TB] CR/LF handling");
`ifdef PASTE_LF_STRIP_EN
        n_exp = 2;
`else
        n_exp = 3;
`endif
        base = bytes_a.size();
        peak = 0;
        fork
            begin
                apply_stimulus(0, 8'h41, 1'b1);
                apply_stimulus(0, 8'h0D, 1'b1);
                apply_stimulus(0, 8'h0A, 1'b1);
            end
            for (int t = 0; t < 3000; t++) begin
                @(negedge clk);
                if (int'(fifo_count_a) > peak) peak = int'(fifo_count_a);
            end
        join
        check_output("lf_byte_total", bytes_a.size() - base, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (base + i < bytes_a.size())
                check_output($sformatf("lf_byte%0d", i), int'(bytes_a[base + i]), int'(lf_exp[i]));
        end
        check_output("lf_peak_nonzero", int'(peak >= 1), 1);
        check_output("lf_peak_le2", int'(peak <= 2), 1);
        check_output("lf_idle", int'(busy_a), 0);

        $display("[TB] overrun on 4-entry FIFO");
        apply_stimulus(1, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) apply_stimulus(1, 8'h31 + 8'(i), 1'b1);
        repeat (4) @(negedge clk);
        check_output("ovr_count_full", int'(fifo_count_b), 4);
        check_output("ovr_not_yet", int'(overrun_b), 0);
        apply_stimulus(1, 8'h35, 1'b1);
        apply_stimulus(1, 8'h36, 1'b1);
        repeat (4) @(negedge clk);
        check_output("ovr_count_held", int'(fifo_count_b), 4);
        check_output("ovr_set", int'(overrun_b), 1);
        check_output("ovr_busy", int'(busy_b), 1);
        repeat (300) @(negedge clk);
        check_output("ovr_sticky", int'(overrun_b), 1);
        check_output("ovr_a_untouched", int'(overrun_a), 0);
        reset_n = 1'b0;
        #1;
        check_output("ovr_reset_clear", int'(overrun_b), 0);
        check_output("ovr_reset_count", int'(fifo_count_b), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        $display("[TB] reset during data bit 3 of 0x55");
        s0 = starts_a.size();
        apply_stimulus(0, 8'h55, 1'b1);
        ok = 0;
        for (int t = 0; t < 400; t++) begin
            if (starts_a.size() > s0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        check_output("mid_start_seen", ok, 1);
        if (ok == 1) begin
            target = starts_a[s0] + CPB + 3 * CPB + CPB / 2;
            for (int t = 0; t < 400; t++) begin
                if (cyc >= target) break;
                @(negedge clk);
            end
            check_output("mid_bit3_low", int'(cpu_rx_a), 0);
            #2;
            reset_n = 1'b0;
            #1;
            check_output("mid_cpu_rx_forced", int'(cpu_rx_a), 1);
            check_output("mid_count", int'(fifo_count_a), 0);
            check_output("mid_busy", int'(busy_a), 0);
            @(negedge clk);
            @(negedge clk);
            reset_n = 1'b1;
            repeat (500) @(negedge clk);
            check_output("mid_no_restart", starts_a.size() - s0, 1);
            check_output("mid_line_idle", int'(cpu_rx_a), 1);
            check_output("mid_busy_after", int'(busy_a), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
